mux8_rr_arbiter: RTL and testbench
==================================

MUX8_RR_ARBITER -- requirements
Module: mux8_rr_arbiter

Interface
REQ-001 SHALL have parameter DW, default 3, width of each requester data word and of out_data.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port req, input, 8, request from requesters 0..7.
REQ-005 SHALL have ports d0..d7, input, DW each, requester data words.
REQ-006 SHALL have port out_data, output, DW, registered data of the granted requester.
REQ-007 SHALL have port out_valid, output, 1, out_data holds an unaccepted word.
REQ-008 SHALL have port out_ready, input, 1, downstream accepts the word.
REQ-009 SHALL have port gnt, output, 8, one-hot owner of out_data; all zero when out_valid is 0.
REQ-010 SHALL have port sel, output, 3, binary index of the gnt bit; 0 when idle.
REQ-011 SHALL have port xfer_cnt, output, 16, count of completed transfers.

Function
REQ-012 SHALL implement two states: IDLE (out_valid=0) and HOLD (out_valid=1).
REQ-013 Transfer SHALL be defined as out_valid=1 and out_ready=1 at a rising edge.
REQ-014 In IDLE with any req bit set at edge N, SHALL capture d[winner] into out_data, set gnt, sel, out_valid after edge N, and enter HOLD (1-cycle latency).
REQ-015 Winner SHALL be the first set req bit searched upward from pointer ptr, wrapping 7->0.
REQ-016 On each capture, ptr SHALL become (winner+1) mod 8; reset value of ptr is 0.
REQ-017 In HOLD without out_ready, out_data, gnt, sel, and out_valid SHALL remain unchanged regardless of req or d.
REQ-018 On a transfer with any req bit set, SHALL re-arbitrate at the same edge and capture the next word with no idle cycle.
REQ-019 On a transfer with req all zero, SHALL return to IDLE and clear out_valid, gnt, and sel.
REQ-020 Requester i SHALL treat gnt[i]&out_valid&out_ready as its completion; req[i] still high on the next cycle is a new request.
REQ-021 Data SHALL be sampled only at capture; later d changes SHALL NOT affect out_data.
REQ-022 xfer_cnt SHALL increment by 1 per transfer and wrap 0xFFFF->0x0000.
REQ-023 A single requester with req held continuously SHALL be granted on every transfer.

Reset
REQ-024 rst_n low SHALL immediately force out_valid=0, out_data=0, gnt=0, sel=0, xfer_cnt=0, ptr=0, and state IDLE, including during HOLD.
REQ-025 The first capture SHALL occur no earlier than the first rising edge after rst_n deasserts.

Configuration
REQ-026 With macro MUX8_ARB_BURST_EN defined, the current owner SHALL retain the grant on a transfer, without advancing ptr, while its req stays high, up to 4 consecutive words; it SHALL then rotate per REQ-015/016.
REQ-027 Without MUX8_ARB_BURST_EN, arbitration SHALL follow REQ-015/016 on every capture.

Verification
REQ-028 Reset, req=8'h01, d0=3'b101, out_ready=1 -> out_valid=1 one cycle later, out_data=3'b101, gnt=8'h01, sel=0, xfer_cnt=1 after that edge.
REQ-029 req=8'hFF held, out_ready=1 (burst off) -> sel sequence 0,1,...,7,0 on consecutive cycles, with no out_valid gap.
REQ-030 Capture from requester 3 (d3=3'b011), out_ready=0 for 5 cycles while d3 changes to 3'b110 -> out_data stays 3'b011; after out_ready=1, one transfer.
REQ-031 ptr=6, req=8'b0000_0101 -> winner 0, then 2; wrap verified.
REQ-032 rst_n pulsed low mid-HOLD -> out_valid, gnt, and xfer_cnt read 0 before the next clk edge.
REQ-033 MUX8_ARB_BURST_EN defined, req=8'h03 held, out_ready=1 -> sel 0,0,0,0,1,1,1,1,0.

Source files
------------

// File: rtl/mux8_rr_arbiter.sv
// Eight-way round-robin arbiter with a registered one-word output stage and transfer counter.
// Optional MUX8_ARB_BURST_EN lets an owner keep the grant for up to 4 consecutive words.
module mux8_rr_arbiter #(
    parameter int unsigned DW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    req,
    input  logic [DW-1:0] d0,
    input  logic [DW-1:0] d1,
    input  logic [DW-1:0] d2,
    input  logic [DW-1:0] d3,
    input  logic [DW-1:0] d4,
    input  logic [DW-1:0] d5,
    input  logic [DW-1:0] d6,
    input  logic [DW-1:0] d7,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    gnt,
    output logic [2:0]    sel,
    output logic [15:0]   xfer_cnt
);

    typedef enum logic [0:0] {StIdle, StHold} state_e;

    state_e        r_state, w_state_d;
    logic [2:0]    r_ptr, w_ptr_d;
    logic [2:0]    r_sel, w_sel_d;
    logic [7:0]    r_gnt, w_gnt_d;
    logic [DW-1:0] r_data, w_data_d;
    logic [15:0]   r_cnt, w_cnt_d;
    logic [2:0]    w_winner;
    logic          w_found;
    logic          w_xfer;
    logic          w_capture;
    logic          w_keep;
    logic [DW-1:0] w_d [8];

    assign w_d[0] = d0;
    assign w_d[1] = d1;
    assign w_d[2] = d2;
    assign w_d[3] = d3;
    assign w_d[4] = d4;
    assign w_d[5] = d5;
    assign w_d[6] = d6;
    assign w_d[7] = d7;

    assign w_xfer    = (r_state == StHold) && out_ready;
    // In IDLE nothing is held, so any request captures; in HOLD only a transfer frees the stage.
    assign w_capture = ((r_state == StIdle) || w_xfer) && (|req);

    // First set request at or above the pointer, wrapping 7 -> 0.
    always_comb begin
        logic [2:0] idx;
        idx      = '0;
        w_winner = r_ptr;
        w_found  = 1'b0;
        for (int k = 0; k < 8; k++) begin
            idx = r_ptr + 3'(k);
            if (!w_found && req[idx]) begin
                w_winner = idx;
                w_found  = 1'b1;
            end
        end
    end

`ifdef MUX8_ARB_BURST_EN
    logic [2:0] r_burst;

    assign w_keep = w_xfer && req[r_sel] && (r_burst < 3'd4);

    // Words delivered by the current owner in its ongoing burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_burst <= 3'd0;
        end else if (w_capture) begin
            r_burst <= w_keep ? r_burst + 3'd1 : 3'd1;
        end
    end
`else
    assign w_keep = 1'b0;
`endif

    always_comb begin
        w_state_d = r_state;
        w_ptr_d   = r_ptr;
        w_sel_d   = r_sel;
        w_gnt_d   = r_gnt;
        w_data_d  = r_data;
        w_cnt_d   = r_cnt + 16'(w_xfer);
        if (w_capture) begin
            w_state_d = StHold;
            if (w_keep) begin
                w_data_d = w_d[r_sel];
            end else begin
                w_sel_d  = w_winner;
                w_gnt_d  = 8'b1 << w_winner;
                w_data_d = w_d[w_winner];
                w_ptr_d  = w_winner + 3'd1;
            end
        end else if (w_xfer) begin
            w_state_d = StIdle;
            w_sel_d   = 3'd0;
            w_gnt_d   = 8'h00;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_ptr   <= 3'd0;
            r_sel   <= 3'd0;
            r_gnt   <= 8'h00;
            r_data  <= '0;
            r_cnt   <= 16'h0000;
        end else begin
            r_state <= w_state_d;
            r_ptr   <= w_ptr_d;
            r_sel   <= w_sel_d;
            r_gnt   <= w_gnt_d;
            r_data  <= w_data_d;
            r_cnt   <= w_cnt_d;
        end
    end

    assign out_valid = (r_state == StHold);
    assign out_data  = r_data;
    assign gnt       = r_gnt;
    assign sel       = r_sel;
    assign xfer_cnt  = r_cnt;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Randomized and directed bench for mux8_rr_arbiter against a behavioural round-robin model.
// Honours MUX8_ARB_BURST_EN the same way the design does.
module tb_mux8_rr_arbiter;

`ifdef MUX8_ARB_BURST_EN
    localparam bit Burst = 1'b1;
`else
    localparam bit Burst = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  req;
    logic [2:0]  d [8];
    logic [2:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  gnt;
    logic [2:0]  sel;
    logic [15:0] xfer_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model state
    bit          m_valid;
    int          m_ptr;
    int          m_sel;
    int          m_run;
    logic [2:0]  m_data;
    logic [15:0] m_cnt;

    always #5 clk = ~clk;

    mux8_rr_arbiter #(.DW(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .d0        (d[0]),
        .d1        (d[1]),
        .d2        (d[2]),
        .d3        (d[3]),
        .d4        (d[4]),
        .d5        (d[5]),
        .d6        (d[6]),
        .d7        (d[7]),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .gnt       (gnt),
        .sel       (sel),
        .xfer_cnt  (xfer_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_ptr   = 0;
        m_sel   = 0;
        m_run   = 0;
        m_data  = 3'b000;
        m_cnt   = 16'h0000;
    endtask

    // Advance the model by one rising edge using the inputs currently applied.
    task automatic model_step();
        bit xf;
        int w;
        xf = m_valid && out_ready;
        if (xf) m_cnt = m_cnt + 16'd1;
        if ((!m_valid || xf) && req != 8'h00) begin
            if (Burst && xf && req[m_sel] && m_run < 4) begin
                m_data = d[m_sel];
                m_run++;
            end else begin
                w = -1;
                for (int k = 0; k < 8; k++) begin
                    if (w < 0 && req[(m_ptr + k) % 8]) w = (m_ptr + k) % 8;
                end
                m_sel  = w;
                m_data = d[w];
                m_ptr  = (w + 1) % 8;
                m_run  = 1;
            end
            m_valid = 1'b1;
        end else if (xf) begin
            m_valid = 1'b0;
            m_sel   = 0;
        end
    endtask

    task automatic compare_all(input string tag);
        check_eq({tag, ".valid"}, 32'(out_valid), 32'(m_valid));
        check_eq({tag, ".gnt"}, 32'(gnt), m_valid ? 32'(8'b1 << m_sel) : 32'h0);
        check_eq({tag, ".sel"}, 32'(sel), 32'(m_sel));
        check_eq({tag, ".cnt"}, 32'(xfer_cnt), 32'(m_cnt));
        if (m_valid) check_eq({tag, ".data"}, 32'(out_data), 32'(m_data));
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("rst.valid", 32'(out_valid), 32'h0);
        check_eq("rst.data", 32'(out_data), 32'h0);
        check_eq("rst.gnt", 32'(gnt), 32'h0);
        check_eq("rst.sel", 32'(sel), 32'h0);
        check_eq("rst.cnt", 32'(xfer_cnt), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b1;
        req       = 8'h00;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) d[i] = 3'(i);
        model_reset();
        #2;

        // Single requester, basic latency and counting
        do_reset();
        req       = 8'h01;
        d[0]      = 3'b101;
        out_ready = 1'b1;
        tick("basic1");
        check_eq("basic.data", 32'(out_data), 32'h5);
        check_eq("basic.gnt", 32'(gnt), 32'h01);
        tick("basic2");
        check_eq("basic.cnt", 32'(xfer_cnt), 32'h1);
        for (int i = 0; i < 3; i++) tick("single_hold");

`ifndef MUX8_ARB_BURST_EN
        // All requesting: strict rotation with no bubble
        do_reset();
        req = 8'hFF;
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick("rot");
            check_eq("rot.sel", 32'(sel), 32'(i % 8));
            check_eq("rot.valid", 32'(out_valid), 32'h1);
        end
`else
        do_reset();
        req = 8'h03;
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick("burst");
            check_eq("burst.sel", 32'(sel), 32'((i / 4) % 2));
        end
`endif

        // Hold stability while data input changes
        do_reset();
        req       = 8'h08;
        d[3]      = 3'b011;
        out_ready = 1'b0;
        tick("hold_cap");
        req  = 8'hFF;
        d[3] = 3'b110;
        for (int i = 0; i < 5; i++) begin
            tick("hold");
            check_eq("hold.data", 32'(out_data), 32'h3);
        end
        req       = 8'h00;
        out_ready = 1'b1;
        tick("hold_rel");
        check_eq("hold_rel.cnt", 32'(xfer_cnt), 32'h1);
        check_eq("hold_rel.valid", 32'(out_valid), 32'h0);

        // Pointer wrap from 6
        do_reset();
        req       = 8'h20;
        out_ready = 1'b1;
        tick("wrap_a");
        req = 8'h00;
        tick("wrap_b");
        req = 8'h05;
        tick("wrap_c");
        check_eq("wrap.sel0", 32'(sel), 32'h0);
        tick("wrap_d");
        check_eq("wrap.sel2", 32'(sel), 32'h2);
        tick("wrap_e");

        // Asynchronous reset in the middle of HOLD
        out_ready = 1'b0;
        tick("mid_hold");
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async.valid", 32'(out_valid), 32'h0);
        check_eq("async.gnt", 32'(gnt), 32'h0);
        check_eq("async.cnt", 32'(xfer_cnt), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0: req = 8'h00;
                1: req = 8'(1 << $urandom_range(0, 7));
                2: req = 8'($urandom) & 8'($urandom);
                default: req = 8'($urandom);
            endcase
            for (int j = 0; j < 8; j++) d[j] = 3'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            tick("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
